// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch/decode boundary: the word type,
// the bubble instruction, the default reset PC and the IF/ID update kinds.
package cpu_pkg;

  typedef logic [31:0] word_t;

  // MIPS "sll $0,$0,0", inserted as a bubble on flush or reset.
  localparam word_t NOP_INSN         = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // What the PC and IF/ID register do on a non-reset edge.
  typedef enum logic [1:0] {
    UPD_NORMAL = 2'd0,
    UPD_STALL  = 2'd1,
    UPD_FLUSH  = 2'd2
  } upd_e;

  // Fetch PCs are always word-aligned; the low two bits are dropped.
  function automatic word_t align_pc(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register_if.sv
// Fetch/decode signal bundle around the IF/ID boundary register.
// slave  : the boundary register itself.
// master : the surrounding fetch stage, hazard unit and decode stage.
interface if_id_register_if;
  import cpu_pkg::*;

  word_t if_nextPc;
  word_t if_pc_4;
  word_t if_instruction;
  logic  stall;
  logic  flush;

  word_t pc;
  word_t id_pc_4;
  word_t id_instruction;
  logic  id_valid;
  word_t stallCycles;
  word_t flushCount;
  logic  pcMisaligned;

  modport slave (
    input  if_nextPc, if_pc_4, if_instruction, stall, flush,
    output pc, id_pc_4, id_instruction, id_valid,
           stallCycles, flushCount, pcMisaligned
  );

  modport master (
    output if_nextPc, if_pc_4, if_instruction, stall, flush,
    input  pc, id_pc_4, id_instruction, id_valid,
           stallCycles, flushCount, pcMisaligned
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones and holds there until reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count one per enabled cycle, never wrapping past the maximum value.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline boundary: owns the architectural fetch PC and the
// instruction/pc+4 handed to decode. Priority per edge is
// reset > stall > flush > normal. Stall and flush events are counted,
// and a sticky flag records any misaligned next-PC that was loaded.
module if_id_register
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t NOP_INSN = cpu_pkg::NOP_INSN
) (
  input logic               clk,
  input logic               rst,
  if_id_register_if.slave   bus
);

  upd_e  upd;

  word_t pc_q,        pc_d;
  word_t id_pc_4_q,   id_pc_4_d;
  word_t id_insn_q,   id_insn_d;
  logic  id_valid_q,  id_valid_d;
  logic  misalign_q,  misalign_d;

  // Resolve stall-over-flush priority once; a flush during a stall is dropped.
  always_comb begin
    if (bus.stall) begin
      upd = UPD_STALL;
    end else if (bus.flush) begin
      upd = UPD_FLUSH;
    end else begin
      upd = UPD_NORMAL;
    end
  end

  // Next-state for the PC, IF/ID contents and the sticky misalignment flag.
  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    pc_d       = pc_q;
    id_pc_4_d  = id_pc_4_q;
    id_insn_d  = id_insn_q;
    id_valid_d = id_valid_q;
    misalign_d = misalign_q;

    unique case (upd)
      UPD_STALL: begin
        // Everything holds; only the stall counter moves.
      end
      UPD_FLUSH: begin
        pc_d       = align_pc(bus.if_nextPc);
        id_insn_d  = NOP_INSN;
        id_pc_4_d  = bus.if_pc_4;
        id_valid_d = 1'b0;
        misalign_d = misalign_q | (bus.if_nextPc[1:0] != 2'b00);
      end
      default: begin
        pc_d       = align_pc(bus.if_nextPc);
        id_insn_d  = bus.if_instruction;
        id_pc_4_d  = bus.if_pc_4;
        id_valid_d = 1'b1;
        misalign_d = misalign_q | (bus.if_nextPc[1:0] != 2'b00);
      end
    endcase
  end

  // PC, IF/ID register and debug flag with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_4_q  <= '0;
      id_insn_q  <= NOP_INSN;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_4_q  <= id_pc_4_d;
      id_insn_q  <= id_insn_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

  logic stall_inc;
  logic flush_inc;

  // Only applied events count: a flush shadowed by a stall is not a flush.
  assign stall_inc = (upd == UPD_STALL);
  assign flush_inc = (upd == UPD_FLUSH);

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (bus.stallCycles)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (bus.flushCount)
  );

  assign bus.pc             = pc_q;
  assign bus.id_pc_4        = id_pc_4_q;
  assign bus.id_instruction = id_insn_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.pcMisaligned   = misalign_q;

endmodule

// File: tb/tb_if_id_register.sv
// Directed bench for if_id_register. The driver applies one vector per
// cycle and queues the hand-computed outputs expected after the next edge;
// a separate monitor pops and compares after every rising edge.
module tb_if_id_register;
  import cpu_pkg::*;

  logic clk;
  logic rst;

  if_id_register_if bus ();

  if_id_register dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] insn;
    logic        v;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] insn, input logic v,
                              input logic [31:0] sc, input logic [31:0] fc,
                              input logic mis);
    exp_t e;
    e.id = '0; e.pc = pc; e.pc4 = pc4; e.insn = insn; e.v = v;
    e.sc = sc; e.fc = fc; e.mis = mis;
    return e;
  endfunction

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Apply one vector (called at a falling edge), queue its expected result.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] npc, input logic [31:0] p4,
                      input logic [31:0] ins, input exp_t e);
    exp_t t;
    rst                = r;
    bus.stall          = s;
    bus.flush          = f;
    bus.if_nextPc      = npc;
    bus.if_pc_4        = p4;
    bus.if_instruction = ins;
    t    = e;
    t.id = vec_no[7:0];
    vec_no++;
    exp_q.push_back(t);
    @(negedge clk);
  endtask

  // Monitor: compare every output after each rising edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",             e.id, bus.pc,                 e.pc);
        check("id_pc_4",        e.id, bus.id_pc_4,            e.pc4);
        check("id_instruction", e.id, bus.id_instruction,     e.insn);
        check("id_valid",       e.id, {31'b0, bus.id_valid},  {31'b0, e.v});
        check("stallCycles",    e.id, bus.stallCycles,        e.sc);
        check("flushCount",     e.id, bus.flushCount,         e.fc);
        check("pcMisaligned",   e.id, {31'b0, bus.pcMisaligned}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    // Reset held for 3 cycles with random inputs, including stall/flush.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           mk(32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0));
    end
    // First fetch at RESET_PC, redirect to 4.
    step(0, 0, 0, 32'h4, 32'h4, 32'h2402_0001,
         mk(32'h4, 32'h4, 32'h2402_0001, 1, 0, 0, 0));
    // Straight-line fetch.
    step(0, 0, 0, 32'h8, 32'h8, 32'h2008_0005,
         mk(32'h8, 32'h8, 32'h2008_0005, 1, 0, 0, 0));
    // Stall 3 cycles with changing inputs: everything frozen.
    step(0, 1, 0, 32'h100, 32'h104, 32'h1111_1111,
         mk(32'h8, 32'h8, 32'h2008_0005, 1, 1, 0, 0));
    step(0, 1, 0, 32'h203, 32'h208, 32'h2222_2222,
         mk(32'h8, 32'h8, 32'h2008_0005, 1, 2, 0, 0));
    step(0, 1, 0, 32'h300, 32'h304, 32'h3333_3333,
         mk(32'h8, 32'h8, 32'h2008_0005, 1, 3, 0, 0));
    // Flush: bubble inserted, pc redirected.
    step(0, 0, 1, 32'h40, 32'hC, 32'hDEAD_BEEF,
         mk(32'h40, 32'hC, 32'h0, 0, 3, 1, 0));
    // Normal fetch after flush.
    step(0, 0, 0, 32'h44, 32'h44, 32'h8C43_0000,
         mk(32'h44, 32'h44, 32'h8C43_0000, 1, 3, 1, 0));
    // Stall and flush together: stall wins, flush not counted.
    step(0, 1, 1, 32'h80, 32'h48, 32'h0000_1234,
         mk(32'h44, 32'h44, 32'h8C43_0000, 1, 4, 1, 0));
    // Reasserted flush after the stall.
    step(0, 0, 1, 32'h80, 32'h48, 32'h0000_1111,
         mk(32'h80, 32'h48, 32'h0, 0, 4, 2, 0));
    // Misaligned next PC: aligned load, sticky flag set.
    step(0, 0, 0, 32'h46, 32'h84, 32'h0062_2020,
         mk(32'h44, 32'h84, 32'h0062_2020, 1, 4, 2, 1));
    // Aligned PC afterwards: flag stays set.
    step(0, 0, 0, 32'h48, 32'h48, 32'hAC43_0004,
         mk(32'h48, 32'h48, 32'hAC43_0004, 1, 4, 2, 1));
    step(0, 1, 0, 32'h4B, 32'h4C, 32'h5555_5555,
         mk(32'h48, 32'h48, 32'hAC43_0004, 1, 5, 2, 1));
    // Reset during stall and flush overrides both.
    step(1, 1, 1, 32'h77, 32'h78, 32'h6666_6666,
         mk(32'h0, 32'h0, 32'h0, 0, 0, 0, 0));
    // Misaligned target on the flush path also sets the flag.
    step(0, 0, 1, 32'h101, 32'h4, 32'h0000_2222,
         mk(32'h100, 32'h4, 32'h0, 0, 0, 1, 1));
    step(1, 0, 0, 32'h0, 32'h0, 32'h0,
         mk(32'h0, 32'h0, 32'h0, 0, 0, 0, 0));
    // A misaligned next PC while stalled is not loaded, so no flag.
    step(0, 1, 0, 32'h3, 32'h4, 32'h0000_3333,
         mk(32'h0, 32'h0, 32'h0, 0, 1, 0, 0));
    // Saturation: preload the stall counter just below the maximum.
    force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count_q;
    step(0, 1, 0, 32'h10, 32'h14, 32'h0000_0010,
         mk(32'h0, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0));
    step(0, 1, 0, 32'h20, 32'h24, 32'h0000_0020,
         mk(32'h0, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0));
    step(0, 1, 0, 32'h30, 32'h34, 32'h0000_0030,
         mk(32'h0, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0));
    step(0, 0, 0, 32'h8, 32'h8, 32'h1234_5678,
         mk(32'h8, 32'h8, 32'h1234_5678, 1, 32'hFFFF_FFFF, 0, 0));

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
